// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM state, forwarding
// select codes and the hardwired-zero register number.
package hazard_pkg;

  typedef enum logic {RUN = 1'b0, MULTI = 1'b1} state_t;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  localparam logic [4:0] REG_ZERO = 5'd0;

  // EX/MEM result is younger than MEM/WB, so it wins when both match.
  function automatic logic [1:0] fwd_pick(input logic [4:0] src,
                                          input logic       mem_rw,
                                          input logic [4:0] mem_wn,
                                          input logic       wb_rw,
                                          input logic [4:0] wb_wn);
    if (mem_rw && mem_wn != REG_ZERO && mem_wn == src) return FWD_MEM;
    if (wb_rw  && wb_wn  != REG_ZERO && wb_wn  == src) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// EX-stage operand forwarding compare; one lane per ALU source operand.
module fwd_unit
  import hazard_pkg::*;
#(
  parameter int NUM_LANES = 2
) (
  input  logic [NUM_LANES-1:0][4:0] src,
  input  logic                      mem_regwrite,
  input  logic [4:0]                mem_wn,
  input  logic                      wb_regwrite,
  input  logic [4:0]                wb_wn,
  output logic [NUM_LANES-1:0][1:0] sel
);

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++)
      sel[i] = fwd_pick(src[i], mem_regwrite, mem_wn, wb_regwrite, wb_wn);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: load-use bubbles,
// multi-cycle ALU stalls, MEM-resolved redirect flushes, forwarding, counters.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = 32,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_wn,
  input  logic             ex_multi,
  input  logic             mem_regwrite,
  input  logic [4:0]       mem_wn,
  input  logic             wb_regwrite,
  input  logic [4:0]       wb_wn,
  input  logic             mem_redirect,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             idex_en,
  output logic             exmem_bubble,
  output logic             alu_start,
  output logic             alu_busy,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int            CW       = $clog2(MULT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MULT_CYCLES - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          lu;
  logic [1:0][1:0] fsel;

  assign lu = ex_mem_read && ex_wn != REG_ZERO &&
              (ex_wn == id_rs || (id_uses_rt && ex_wn == id_rt));

  fwd_unit #(.NUM_LANES(2)) u_fwd (
    .src          ({ex_rs, ex_rt}),
    .mem_regwrite (mem_regwrite),
    .mem_wn       (mem_wn),
    .wb_regwrite  (wb_regwrite),
    .wb_wn        (wb_wn),
    .sel          (fsel)
  );
  assign fwd_a = fsel[1];
  assign fwd_b = fsel[0];

  // Redirect outranks everything, including an in-flight multi op (abort).
  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    alu_start    = 1'b0;
    alu_busy     = (state == MULTI);
    if (mem_redirect) begin
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      exmem_bubble = 1'b1;
    end else if (state == MULTI) begin
      if (cnt != '0) begin
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        idex_en      = 1'b0;
        exmem_bubble = 1'b1;
      end
    end else if (ex_multi) begin
      alu_start    = 1'b1;
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_bubble = 1'b1;
    end else if (lu) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= RUN;
      cnt          <= '0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      case (state)
        RUN: if (!mem_redirect && ex_multi) begin
          state <= MULTI;
          cnt   <= CNT_LOAD;
        end
        MULTI: if (mem_redirect || cnt == '0) begin
          state <= RUN;
          cnt   <= '0;
        end else begin
          cnt <= cnt - 1'b1;
        end
        default: state <= RUN;
      endcase
      if (!pc_en && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
      if (mem_redirect && flush_count != '1) flush_count <= flush_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Table vectors, hand sequences and a randomized run against a cycle model
// for pipe_hazard_ctrl (MULT_CYCLES=4) plus a small-counter instance.
module tb_pipe_hazard_ctrl;

  localparam int MC = 4;

  logic clk = 1'b0, rst = 1'b0;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_wn, mem_wn, wb_wn;
  logic id_uses_rt, ex_mem_read, ex_multi, mem_regwrite, wb_regwrite, mem_redirect;

  logic pc_en, ifid_en, ifid_flush, idex_bubble, idex_en, exmem_bubble, alu_start, alu_busy;
  logic [1:0] fwd_a, fwd_b;
  logic [15:0] stall_cycles, flush_count;

  logic pc_en2, ifid_en2, ifid_flush2, idex_bubble2, idex_en2, exmem_bubble2, alu_start2, alu_busy2;
  logic [1:0] fwd_a2, fwd_b2;
  logic [3:0] stall_cycles2, flush_count2;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MULT_CYCLES(MC), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_mem_read(ex_mem_read), .ex_wn(ex_wn),
    .ex_multi(ex_multi), .mem_regwrite(mem_regwrite), .mem_wn(mem_wn),
    .wb_regwrite(wb_regwrite), .wb_wn(wb_wn), .mem_redirect(mem_redirect),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .idex_en(idex_en), .exmem_bubble(exmem_bubble), .alu_start(alu_start),
    .alu_busy(alu_busy), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cycles(stall_cycles), .flush_count(flush_count));

  pipe_hazard_ctrl #(.MULT_CYCLES(32), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_mem_read(ex_mem_read), .ex_wn(ex_wn),
    .ex_multi(ex_multi), .mem_regwrite(mem_regwrite), .mem_wn(mem_wn),
    .wb_regwrite(wb_regwrite), .wb_wn(wb_wn), .mem_redirect(mem_redirect),
    .pc_en(pc_en2), .ifid_en(ifid_en2), .ifid_flush(ifid_flush2), .idex_bubble(idex_bubble2),
    .idex_en(idex_en2), .exmem_bubble(exmem_bubble2), .alu_start(alu_start2),
    .alu_busy(alu_busy2), .fwd_a(fwd_a2), .fwd_b(fwd_b2),
    .stall_cycles(stall_cycles2), .flush_count(flush_count2));

  // {pc_en, ifid_en, ifid_flush, idex_bubble, idex_en, exmem_bubble, alu_start, alu_busy, fwd_a, fwd_b}
  logic [11:0] act;
  assign act = {pc_en, ifid_en, ifid_flush, idex_bubble, idex_en, exmem_bubble,
                alu_start, alu_busy, fwd_a, fwd_b};

  int nvec = 0, nerr = 0;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic quiet;
    id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 1'b1; ex_rs = 5'd3; ex_rt = 5'd4;
    ex_mem_read = 1'b0; ex_wn = 5'd5; ex_multi = 1'b0; mem_regwrite = 1'b0;
    mem_wn = 5'd0; wb_regwrite = 1'b0; wb_wn = 5'd0; mem_redirect = 1'b0;
  endtask

  task automatic do_reset;
    quiet();
    rst = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
  endtask

  // Reference model: occupancy bookkeeping in plain integers.
  int m_left, m_stall, m_flush;

  function automatic logic [1:0] ref_fwd(input logic [4:0] s);
    if (mem_regwrite && mem_wn != 0 && mem_wn == s) return 2'd2;
    if (wb_regwrite && wb_wn != 0 && wb_wn == s) return 2'd1;
    return 2'd0;
  endfunction

  task automatic model_cycle(output logic [11:0] e);
    bit lu, pc, ifd, fl, bub, idx, exb, st, busy;
    int sat;
    sat = 65535;
    lu = ex_mem_read && ex_wn != 0 && (ex_wn == id_rs || (id_uses_rt && ex_wn == id_rt));
    pc = 1; ifd = 1; idx = 1; fl = 0; bub = 0; exb = 0; st = 0;
    busy = (m_left > 0);
    if (mem_redirect) begin
      fl = 1; bub = 1; exb = 1; m_left = 0;
      if (m_flush < sat) m_flush++;
    end else if (busy) begin
      if (m_left > 1) begin pc = 0; ifd = 0; idx = 0; exb = 1; end
      m_left--;
    end else if (ex_multi) begin
      st = 1; pc = 0; ifd = 0; idx = 0; exb = 1; m_left = MC;
    end else if (lu) begin
      pc = 0; ifd = 0; bub = 1;
    end
    if (!pc && m_stall < sat) m_stall++;
    e = {pc, ifd, fl, bub, idx, exb, st, busy, ref_fwd(ex_rs), ref_fwd(ex_rt)};
  endtask

  typedef struct {
    string name;
    logic [4:0] id_rs, id_rt; logic id_uses_rt;
    logic [4:0] ex_rs, ex_rt; logic ex_mem_read; logic [4:0] ex_wn; logic ex_multi;
    logic mem_regwrite; logic [4:0] mem_wn; logic wb_regwrite; logic [4:0] wb_wn;
    logic mem_redirect; logic [11:0] exp;
  } vec_t;

  vec_t tbl[11];
  logic [11:0] e;
  int nstall, nstart;

  initial begin
    tbl[0]  = '{"quiet",      1,2,1, 3,4, 0,5, 0, 0,0, 0,0, 0, 12'hC80};
    tbl[1]  = '{"lu_rs",      8,2,1, 3,4, 1,8, 0, 0,0, 0,0, 0, 12'h180};
    tbl[2]  = '{"lu_r0",      0,2,1, 3,4, 1,0, 0, 0,0, 0,0, 0, 12'hC80};
    tbl[3]  = '{"lu_rt",      1,7,1, 3,4, 1,7, 0, 0,0, 0,0, 0, 12'h180};
    tbl[4]  = '{"lu_rt_nouse",1,7,0, 3,4, 1,7, 0, 0,0, 0,0, 0, 12'hC80};
    tbl[5]  = '{"redir_prio", 8,2,1, 3,4, 1,8, 1, 0,0, 0,0, 1, 12'hFC0};
    tbl[6]  = '{"fwd_a_mem",  1,2,1, 9,4, 0,5, 0, 1,9, 1,9, 0, 12'hC88};
    tbl[7]  = '{"fwd_a_wb",   1,2,1, 9,4, 0,5, 0, 0,9, 1,9, 0, 12'hC84};
    tbl[8]  = '{"fwd_b_r0",   1,2,1, 1,0, 0,5, 0, 0,0, 1,0, 0, 12'hC80};
    tbl[9]  = '{"fwd_both",   1,2,1, 6,6, 0,5, 0, 1,6, 1,6, 0, 12'hC8A};
    tbl[10] = '{"fwd_mem_r0", 1,2,1, 0,0, 0,5, 0, 1,0, 0,0, 0, 12'hC80};

    do_reset();
    chk("reset_out", act, 12'hC80);
    chk("reset_stall", stall_cycles, 0);
    chk("reset_flush", flush_count, 0);

    foreach (tbl[i]) begin
      id_rs = tbl[i].id_rs; id_rt = tbl[i].id_rt; id_uses_rt = tbl[i].id_uses_rt;
      ex_rs = tbl[i].ex_rs; ex_rt = tbl[i].ex_rt; ex_mem_read = tbl[i].ex_mem_read;
      ex_wn = tbl[i].ex_wn; ex_multi = tbl[i].ex_multi; mem_regwrite = tbl[i].mem_regwrite;
      mem_wn = tbl[i].mem_wn; wb_regwrite = tbl[i].wb_regwrite; wb_wn = tbl[i].wb_wn;
      mem_redirect = tbl[i].mem_redirect;
      #2;
      chk(tbl[i].name, act, tbl[i].exp);
      step();
    end
    quiet();

    // load-use: exactly one stall cycle
    do_reset();
    id_rs = 5'd8; ex_mem_read = 1'b1; ex_wn = 5'd8;
    #2 chk("lu_pc_en", pc_en, 0);
    step(); quiet();
    #2 chk("lu_release", pc_en, 1);
    chk("lu_stall_cnt", stall_cycles, 1);

    // multi op: 4 stall cycles then completion
    do_reset();
    nstall = 0; nstart = 0;
    ex_multi = 1'b1;
    for (int i = 0; i < MC + 1; i++) begin
      #2;
      if (!pc_en) nstall++;
      if (alu_start) nstart++;
      chk("multi_busy", alu_busy, (i > 0));
      step();
    end
    ex_multi = 1'b0;
    #2 chk("multi_stalls", nstall, MC);
    chk("multi_starts", nstart, 1);
    chk("multi_exit", alu_busy, 0);
    chk("multi_stall_cnt", stall_cycles, MC);

    // redirect aborts an in-flight multi op
    do_reset();
    ex_multi = 1'b1; step();
    mem_redirect = 1'b1;
    #2 chk("abort_out", act, 12'hFD0);
    step(); quiet();
    #2 chk("abort_busy", alu_busy, 0);
    chk("abort_flush_cnt", flush_count, 1);

    // load-use pending behind a multi op gives one bubble after exit
    do_reset();
    ex_multi = 1'b1; id_rs = 5'd8; ex_mem_read = 1'b1; ex_wn = 5'd8;
    repeat (MC + 1) step();
    ex_multi = 1'b0;
    #2 chk("lu_after_multi", {pc_en, idex_bubble}, 2'b01);
    step(); quiet();

    // async reset mid-MULTI on the 32-cycle instance
    do_reset();
    ex_multi = 1'b1;
    repeat (6) step();
    ex_multi = 1'b0;
    #2 chk("mid_multi_busy", alu_busy2, 1);
    rst = 1'b0;
    #1 chk("async_rst_busy", alu_busy2, 0);
    chk("async_rst_pc_en", pc_en2, 1);
    chk("async_rst_stall", stall_cycles2, 0);
    step(); rst = 1'b1; step();

    // 4-bit stall counter saturates
    ex_multi = 1'b1;
    repeat (20) step();
    #2 chk("sat_stall_a", stall_cycles2, 15);
    repeat (10) step();
    #2 chk("sat_stall_b", stall_cycles2, 15);
    ex_multi = 1'b0;

    // randomized run against the model
    do_reset();
    m_left = 0; m_stall = 0; m_flush = 0;
    for (int c = 0; c < 600; c++) begin
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      id_uses_rt = 1'($urandom); ex_rs = 5'($urandom_range(0, 3));
      ex_rt = 5'($urandom_range(0, 3)); ex_mem_read = ($urandom_range(0, 2) == 0);
      ex_wn = 5'($urandom_range(0, 3)); ex_multi = ($urandom_range(0, 7) == 0);
      mem_regwrite = 1'($urandom); mem_wn = 5'($urandom_range(0, 3));
      wb_regwrite = 1'($urandom); wb_wn = 5'($urandom_range(0, 3));
      mem_redirect = ($urandom_range(0, 9) == 0);
      #2;
      chk("rand_stall", stall_cycles, m_stall);
      chk("rand_flush", flush_count, m_flush);
      model_cycle(e);
      chk("rand_out", act, e);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
